glb_io_stream_ctrl: RTL and testbench
=====================================

Name: glb_io_stream_ctrl

Overview:
- Per-column stream controller between the global buffer (GLB) and one CGRA IO tile of the interconnect.
- Load path: forwards words from a GLB read stream (valid/ready) onto the tile's glb2io_16 / glb2io_1 pins.
- Store path: captures io2glb_16 words qualified by io2glb_1 into a FIFO that drains to the GLB write stream.
- Programmed through the same 32-bit config bus (addr/data/read/write) that configures the interconnect.

Parameters:
- TILE_ID, 0, column id matched against config_addr[31:24]
- DEPTH, 8, store FIFO depth in words; power of two, ≥2
- LEN_W, 16, width of the load word-count register

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-low reset
- stall  in  1  global stall; freezes load issue while high
- config_addr  in  32  [31:24] tile select, [7:0] register offset
- config_data  in  32  write data
- config_read  in  1  read strobe
- config_write  in  1  write strobe
- read_config_data  out  32  registered read data
- src_data  in  16  GLB load word
- src_valid  in  1  load word valid
- src_ready  out  1  load word accepted when src_valid & src_ready
- glb2io_16  out  16  load word to IO tile
- glb2io_1  out  1  load word valid to IO tile, single-cycle per word
- io2glb_16  in  16  store word from IO tile
- io2glb_1  in  1  store word valid
- snk_data  out  16  FIFO head to GLB
- snk_valid  out  1  FIFO non-empty
- snk_ready  in  1  GLB accepts head
- load_done  out  1  one-cycle pulse when the programmed length completes

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; LEN=0; count=0; FIFO empty; overflow=0; done=0; every output = 0.
- Config select: sel = (config_addr[31:24]==TILE_ID).
- Register map:
  - 0x00 CTRL (W): bit0 start, ignored unless state is IDLE or DONE; bit1 clear, empties FIFO and clears overflow/done.
  - 0x04 LEN (R/W): LEN_W bits, zero-extended on read.
  - 0x08 STATUS (RO): bit0 busy(STREAM), bit1 done, bit2 overflow, [15:8] FIFO occupancy, [31:16] count.
  - Other offsets read 0.
- read_config_data: updates one cycle after sel & config_read; otherwise holds its previous value. A write and a read in the same cycle return the pre-write value.
- FSM states: IDLE, STREAM, DONE.
  - IDLE/DONE → STREAM on start: count=0, done=0. If LEN==0, go straight to DONE, pulse load_done, set done.
  - STREAM → DONE when the accepted word makes count==LEN: load_done pulses the following cycle, done=1.
  - Start written while in STREAM is ignored.
- src_ready = (state==STREAM) & ~stall. Combinational; must not depend on src_valid.
- On acceptance: next cycle glb2io_16=src_data, glb2io_1=1, count+1. Otherwise glb2io_1=0 and glb2io_16 holds its last value. Load latency is 1 cycle.
- Store FIFO:
  - push = io2glb_1. Push is accepted when not full, or when full with a pop in the same cycle.
  - Push while full with no pop: word dropped, overflow set (sticky until clear).
  - pop = snk_valid & snk_ready. snk_data = head, combinational from storage.
  - Simultaneous push & pop on an empty FIFO: word enters, becomes visible next cycle.
  - Store path ignores stall and FSM state.
- Clear concurrent with a push: clear wins and the pushed word is discarded.
- Pointers wrap modulo DEPTH; occupancy counts 0..DEPTH.
- Reset mid-STREAM: back to IDLE, glb2io_1=0 next cycle, no load_done pulse.

Test Plan:
- Write LEN=4, start. Hold src_valid=1 with data 0xA000..0xA003 → glb2io_1 high 4 cycles carrying 0xA000..0xA003, each one cycle after acceptance; load_done pulses once; STATUS reads 0x0004_0002.
- Same run with stall=1 for cycles 2-3 → src_ready low for those cycles, no glb2io_1, still exactly 4 words, count=4.
- LEN=0, start → immediate DONE, load_done pulse, src_ready never asserted.
- snk_ready=0, push 9 words (DEPTH=8) → occupancy 8, overflow=1, 9th word lost. Then snk_ready=1 → 8 words drain in order.
- FIFO full with push and pop in the same cycle → occupancy stays 8, overflow stays 0, the new word appears last.
- Config_addr[31:24]≠TILE_ID on write of LEN=7 → LEN unchanged. Read of 0x04 with matching id returns the value on the next cycle. Reset asserted mid-stream → outputs 0, state IDLE.

Source files
------------

// File: rtl/glb_io_stream_ctrl.sv
`default_nettype none
// glb_io_stream_ctrl -- per-column GLB <-> IO-tile stream controller: counted load path,
// store FIFO and config-bus register file.  Rev 1.0
module glb_io_stream_ctrl #(
  parameter int TILE_ID = 0,
  parameter int DEPTH   = 8,
  parameter int LEN_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] config_addr,
  input  logic [31:0] config_data,
  input  logic        config_read,
  input  logic        config_write,
  output logic [31:0] read_config_data,
  input  logic [15:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [15:0] glb2io_16,
  output logic        glb2io_1,
  input  logic [15:0] io2glb_16,
  input  logic        io2glb_1,
  output logic [15:0] snk_data,
  output logic        snk_valid,
  input  logic        snk_ready,
  output logic        load_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_LEN    = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic             sel, cfg_wr, cfg_rd;
  logic [7:0]       offset;
  logic             start, clear, can_start, start_ok;
  logic [LEN_W-1:0] len, count, count_inc;
  logic             accept, last_word, zero_start;
  logic             done_flag, overflow;
  logic [31:0]      rd_mux;

  logic [15:0]      mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      occ;
  logic             full, empty, pop, push_ok;

  // Address bits between the tile id and the offset carry no meaning here.
  logic unused_cfg;
  assign unused_cfg = ^{config_addr[23:8], config_data};

  assign sel       = (config_addr[31:24] == 8'(TILE_ID));
  assign cfg_wr    = sel && config_write;
  assign cfg_rd    = sel && config_read;
  assign offset    = config_addr[7:0];
  assign start     = cfg_wr && (offset == OFF_CTRL) && config_data[0];
  assign clear     = cfg_wr && (offset == OFF_CTRL) && config_data[1];
  assign can_start = (state == IDLE) || (state == DONE);
  assign start_ok  = start && can_start;
  assign count_inc = count + LEN_W'(1);

  assign src_ready = (state == STREAM) && !stall;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_word  = 1'b0;
    zero_start = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (len == '0) begin
            state_next = DONE;
            zero_start = 1'b1;
          end else begin
            state_next = STREAM;
          end
        end
      end
      STREAM: begin
        if (src_valid && !stall) begin
          accept = 1'b1;
          if (count_inc == len) begin
            last_word  = 1'b1;
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Load datapath: one-cycle registered hand-off to the IO tile.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      glb2io_16 <= '0;
      glb2io_1  <= 1'b0;
      load_done <= 1'b0;
    end else begin
      glb2io_1  <= accept;
      load_done <= last_word || zero_start;
      if (accept) begin
        glb2io_16 <= src_data;
        count     <= count_inc;
      end else if (start_ok) begin
        count <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      len <= '0;
    end else if (cfg_wr && (offset == OFF_LEN)) begin
      len <= config_data[LEN_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done_flag <= 1'b0;
    end else if (last_word || zero_start) begin
      done_flag <= 1'b1;
    end else if (start_ok || clear) begin
      done_flag <= 1'b0;
    end
  end

  // Store FIFO: a push into a full FIFO is legal only when the head leaves the same cycle.
  assign full      = (occ == (AW+1)'(DEPTH));
  assign empty     = (occ == '0);
  assign pop       = !empty && snk_ready;
  assign push_ok   = io2glb_1 && (!full || pop);
  assign snk_valid = !empty;
  assign snk_data  = empty ? 16'h0000 : mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wptr] <= io2glb_16;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
      if (io2glb_1 && full && !pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (offset)
      OFF_LEN:    rd_mux = 32'(len);
      OFF_STATUS: rd_mux = {16'(count), 8'(occ), 5'b0, overflow, done_flag, (state == STREAM)};
      default:    rd_mux = 32'h0;
    endcase
  end

  // Read data is sampled before any same-cycle write lands.
  always_ff @(posedge clk) begin
    if (!reset)      read_config_data <= 32'h0;
    else if (cfg_rd) read_config_data <= rd_mux;
  end

endmodule
`default_nettype wire

// File: tb/tb_glb_io_stream_ctrl.sv
`default_nettype none
// tb_glb_io_stream_ctrl -- table-driven load/config vectors plus hand-written FIFO and reset sequences.
module tb_glb_io_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] config_addr = 32'h0;
  logic [31:0] config_data = 32'h0;
  logic        config_read = 1'b0;
  logic        config_write = 1'b0;
  logic [31:0] read_config_data;
  logic [15:0] src_data = 16'h0;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic [15:0] glb2io_16;
  logic        glb2io_1;
  logic [15:0] io2glb_16 = 16'h0;
  logic        io2glb_1 = 1'b0;
  logic [15:0] snk_data;
  logic        snk_valid;
  logic        snk_ready = 1'b0;
  logic        load_done;

  always #5 clk = ~clk;

  glb_io_stream_ctrl #(.TILE_ID(0), .DEPTH(8), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .config_addr(config_addr), .config_data(config_data),
    .config_read(config_read), .config_write(config_write),
    .read_config_data(read_config_data),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .glb2io_16(glb2io_16), .glb2io_1(glb2io_1),
    .io2glb_16(io2glb_16), .io2glb_1(io2glb_1),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .load_done(load_done)
  );

  typedef struct {
    logic        cw;
    logic        cr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        st;
    logic        sv;
    logic [15:0] sd;
    logic        e_rdy;
    logic        e_g1;
    logic [15:0] e_g16;
    logic        e_ld;
    logic [31:0] e_rd;
  } vec_t;

  localparam int NV = 30;
  vec_t vt [NV];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
    config_addr  = a;
    config_data  = d;
    config_write = 1'b1;
    tick();
    config_write = 1'b0;
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    config_addr = 32'h0000_0008;
    config_read = 1'b1;
    tick();
    config_read = 1'b0;
    @(negedge clk);
    chk(name, read_config_data, exp);
    tick();
  endtask

  function automatic vec_t mk(input logic cw, input logic cr, input logic [31:0] a, input logic [31:0] d,
                              input logic st, input logic sv, input logic [15:0] sd,
                              input logic rdy, input logic g1, input logic [15:0] g16,
                              input logic ld, input logic [31:0] rd);
    vec_t v;
    v.cw = cw; v.cr = cr; v.addr = a; v.wdata = d; v.st = st; v.sv = sv; v.sd = sd;
    v.e_rdy = rdy; v.e_g1 = g1; v.e_g16 = g16; v.e_ld = ld; v.e_rd = rd;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // LEN=4 run, data A000..A003
    vt[0]  = mk(1'b1,1'b0,32'h4,32'd4, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'h0000,1'b0,32'h0);
    vt[1]  = mk(1'b1,1'b0,32'h0,32'd1, 1'b0,1'b1,16'hA000, 1'b0,1'b0,16'h0000,1'b0,32'h0);
    vt[2]  = mk(1'b0,1'b0,32'h0,32'd0, 1'b0,1'b1,16'hA000, 1'b1,1'b0,16'h0000,1'b0,32'h0);
    vt[3]  = mk(1'b0,1'b0,32'h0,32'd0, 1'b0,1'b1,16'hA001, 1'b1,1'b1,16'hA000,1'b0,32'h0);
    vt[4]  = mk(1'b0,1'b0,32'h0,32'd0, 1'b0,1'b1,16'hA002, 1'b1,1'b1,16'hA001,1'b0,32'h0);
    vt[5]  = mk(1'b0,1'b0,32'h0,32'd0, 1'b0,1'b1,16'hA003, 1'b1,1'b1,16'hA002,1'b0,32'h0);
    vt[6]  = mk(1'b0,1'b0,32'h0,32'd0, 1'b0,1'b1,16'hA004, 1'b0,1'b1,16'hA003,1'b1,32'h0);
    vt[7]  = mk(1'b0,1'b1,32'h8,32'd0, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'hA003,1'b0,32'h0);
    vt[8]  = mk(1'b0,1'b0,32'h0,32'd0, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'hA003,1'b0,32'h0004_0002);
    // restart from DONE with stall on the 2nd and 3rd cycle of the run
    vt[9]  = mk(1'b1,1'b0,32'h0,32'd1, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'hA003,1'b0,32'h0004_0002);
    vt[10] = mk(1'b0,1'b0,32'h0,32'd0, 1'b0,1'b1,16'hB000, 1'b1,1'b0,16'hA003,1'b0,32'h0004_0002);
    vt[11] = mk(1'b0,1'b0,32'h0,32'd0, 1'b1,1'b1,16'hB001, 1'b0,1'b1,16'hB000,1'b0,32'h0004_0002);
    vt[12] = mk(1'b0,1'b1,32'h8,32'd0, 1'b1,1'b1,16'hB001, 1'b0,1'b0,16'hB000,1'b0,32'h0004_0002);
    vt[13] = mk(1'b0,1'b0,32'h0,32'd0, 1'b0,1'b1,16'hB001, 1'b1,1'b0,16'hB000,1'b0,32'h0001_0001);
    vt[14] = mk(1'b0,1'b0,32'h0,32'd0, 1'b0,1'b1,16'hB002, 1'b1,1'b1,16'hB001,1'b0,32'h0001_0001);
    vt[15] = mk(1'b0,1'b0,32'h0,32'd0, 1'b0,1'b1,16'hB003, 1'b1,1'b1,16'hB002,1'b0,32'h0001_0001);
    vt[16] = mk(1'b0,1'b1,32'h8,32'd0, 1'b0,1'b0,16'h0000, 1'b0,1'b1,16'hB003,1'b1,32'h0001_0001);
    vt[17] = mk(1'b0,1'b0,32'h0,32'd0, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'hB003,1'b0,32'h0004_0002);
    // LEN=0 start: immediate DONE, src_ready stays low
    vt[18] = mk(1'b1,1'b0,32'h4,32'd0, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'hB003,1'b0,32'h0004_0002);
    vt[19] = mk(1'b1,1'b0,32'h0,32'd1, 1'b0,1'b1,16'h0000, 1'b0,1'b0,16'hB003,1'b0,32'h0004_0002);
    vt[20] = mk(1'b0,1'b1,32'h8,32'd0, 1'b0,1'b1,16'h0000, 1'b0,1'b0,16'hB003,1'b1,32'h0004_0002);
    vt[21] = mk(1'b0,1'b0,32'h0,32'd0, 1'b0,1'b1,16'h0000, 1'b0,1'b0,16'hB003,1'b0,32'h0000_0002);
    // tile select, read timing, same-cycle write/read, unmapped offset
    vt[22] = mk(1'b1,1'b0,32'h0700_0004,32'd7, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'hB003,1'b0,32'h0000_0002);
    vt[23] = mk(1'b0,1'b1,32'h0000_0004,32'd0, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'hB003,1'b0,32'h0000_0002);
    vt[24] = mk(1'b1,1'b0,32'h0000_0004,32'd5, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'hB003,1'b0,32'h0);
    vt[25] = mk(1'b1,1'b1,32'h0000_0004,32'd9, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'hB003,1'b0,32'h0);
    vt[26] = mk(1'b0,1'b1,32'h0000_0004,32'd0, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'hB003,1'b0,32'd5);
    vt[27] = mk(1'b0,1'b1,32'h0100_0004,32'd0, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'hB003,1'b0,32'd9);
    vt[28] = mk(1'b0,1'b1,32'h0000_000C,32'd0, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'hB003,1'b0,32'd9);
    vt[29] = mk(1'b0,1'b0,32'h0000_0000,32'd0, 1'b0,1'b0,16'h0000, 1'b0,1'b0,16'hB003,1'b0,32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset.src_ready", 32'(src_ready), 32'h0);
    chk("reset.glb2io_1", 32'(glb2io_1), 32'h0);
    chk("reset.glb2io_16", 32'(glb2io_16), 32'h0);
    chk("reset.load_done", 32'(load_done), 32'h0);
    chk("reset.read_config_data", read_config_data, 32'h0);
    chk("reset.snk_valid", 32'(snk_valid), 32'h0);
    chk("reset.snk_data", 32'(snk_data), 32'h0);
    tick();
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      config_write = vt[i].cw;
      config_read  = vt[i].cr;
      config_addr  = vt[i].addr;
      config_data  = vt[i].wdata;
      stall        = vt[i].st;
      src_valid    = vt[i].sv;
      src_data     = vt[i].sd;
      @(negedge clk);
      chk($sformatf("v%0d.src_ready", i), 32'(src_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d.glb2io_1", i), 32'(glb2io_1), 32'(vt[i].e_g1));
      chk($sformatf("v%0d.glb2io_16", i), 32'(glb2io_16), 32'(vt[i].e_g16));
      chk($sformatf("v%0d.load_done", i), 32'(load_done), 32'(vt[i].e_ld));
      chk($sformatf("v%0d.read_config_data", i), read_config_data, vt[i].e_rd);
      tick();
    end
    config_write = 1'b0;
    config_read  = 1'b0;
    stall        = 1'b0;
    src_valid    = 1'b0;

    // Overflow: 9 pushes into an 8-deep FIFO with the sink stalled
    cfg_write(32'h0, 32'd2);
    snk_ready = 1'b0;
    io2glb_1  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      io2glb_16 = 16'hC000 + 16'(i);
      tick();
    end
    io2glb_1 = 1'b0;
    @(negedge clk);
    chk("ovf.snk_valid", 32'(snk_valid), 32'h1);
    chk("ovf.head", 32'(snk_data), 32'h0000_C000);
    tick();
    read_status("ovf.status", 32'h0000_0804);
    snk_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("ovf.drain%0d.valid", i), 32'(snk_valid), 32'h1);
      chk($sformatf("ovf.drain%0d.data", i), 32'(snk_data), 32'(16'hC000 + 16'(i)));
    end
    @(negedge clk);
    chk("ovf.empty", 32'(snk_valid), 32'h0);
    tick();
    snk_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    cfg_write(32'h0, 32'd2);
    io2glb_1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      io2glb_16 = 16'hD000 + 16'(i);
      tick();
    end
    io2glb_16 = 16'hE000;
    snk_ready = 1'b1;
    tick();
    io2glb_1  = 1'b0;
    snk_ready = 1'b0;
    @(negedge clk);
    chk("full.head", 32'(snk_data), 32'h0000_D001);
    tick();
    read_status("full.status", 32'h0000_0800);
    snk_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("full.drain%0d.data", i), 32'(snk_data),
          (i < 7) ? 32'(16'hD001 + 16'(i)) : 32'h0000_E000);
    end
    @(negedge clk);
    chk("full.empty", 32'(snk_valid), 32'h0);
    tick();
    snk_ready = 1'b0;

    // Clear concurrent with a push discards everything
    io2glb_16 = 16'h1111;
    io2glb_1  = 1'b1;
    tick();
    io2glb_16 = 16'hF000;
    cfg_write(32'h0, 32'd2);
    io2glb_1 = 1'b0;
    @(negedge clk);
    chk("clr.snk_valid", 32'(snk_valid), 32'h0);
    tick();

    // Push and pop on an empty FIFO: word visible next cycle
    snk_ready = 1'b1;
    io2glb_16 = 16'h1234;
    io2glb_1  = 1'b1;
    @(negedge clk);
    chk("pe.same_cycle_valid", 32'(snk_valid), 32'h0);
    tick();
    io2glb_1 = 1'b0;
    @(negedge clk);
    chk("pe.next_valid", 32'(snk_valid), 32'h1);
    chk("pe.next_data", 32'(snk_data), 32'h0000_1234);
    tick();
    @(negedge clk);
    chk("pe.drained", 32'(snk_valid), 32'h0);
    tick();
    snk_ready = 1'b0;

    // Reset in the middle of a stream
    cfg_write(32'h4, 32'd3);
    cfg_write(32'h0, 32'd1);
    src_valid = 1'b1;
    src_data  = 16'h5555;
    tick();
    @(negedge clk);
    chk("rst.pre_g1", 32'(glb2io_1), 32'h1);
    chk("rst.pre_g16", 32'(glb2io_16), 32'h0000_5555);
    src_data = 16'h6666;
    reset    = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst.glb2io_1", 32'(glb2io_1), 32'h0);
    chk("rst.glb2io_16", 32'(glb2io_16), 32'h0);
    chk("rst.src_ready", 32'(src_ready), 32'h0);
    chk("rst.load_done", 32'(load_done), 32'h0);
    chk("rst.read_config_data", read_config_data, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("rst.idle%0d.load_done", i), 32'(load_done), 32'h0);
      chk($sformatf("rst.idle%0d.src_ready", i), 32'(src_ready), 32'h0);
    end
    src_valid = 1'b0;
    tick();
    read_status("rst.status", 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
